lsu_mem_master: RTL and testbench
=================================

Name: lsu_mem_master

Overview:
- Load/store initiator between the core's memory stage and the word-addressed data memory.
- Memory side: combinational read, write on posedge when WE is high, 32-bit word per index.
- Converts core byte-address requests (funct3-coded LB/LH/LW/LBU/LHU/SB/SH/SW) into word-index memory cycles.
- Sub-word stores use read-modify-write. Loads are extracted and sign/zero-extended. Fault checks and a one-cycle response pulse complete each request.

Parameters:
- DEPTH_LOG2, 10, log2 of memory depth in words; legal word index range is 0..2^DEPTH_LOG2-1.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset.
- req_valid  input  1  core request strobe.
- req_ready  output  1  high only in IDLE; request accepted when req_valid & req_ready at posedge.
- req_we  input  1  1 = store, 0 = load.
- req_funct3  input  3  RISC-V funct3 of the access.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data; byte/half taken from the low bits.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  32  extended load data; 0 for stores and faults.
- resp_err  output  1  valid with resp_valid; misaligned, out-of-range or illegal funct3.
- mem_A  output  32  word index, {zeros, addr[DEPTH_LOG2+1:2]}.
- mem_WE  output  1  memory write enable.
- mem_WD  output  32  memory write data.
- mem_RD  input  32  memory read data, combinational from mem_A.

Behaviour:
- Reset (rst=0, async) values:
  - State = IDLE, and all latched request registers = 0.
  - req_ready=0 while rst=0; it rises with IDLE after release.
  - resp_valid=0, resp_rdata=0, resp_err=0, mem_A=0, mem_WE=0, mem_WD=0.
- Reset mid-operation:
  - Any request in flight is abandoned with no response.
  - mem_WE drops immediately, so no write occurs at an edge while rst=0.
- FSM states: IDLE, LOAD, RMW, STORE, RESP.
- IDLE, on accept:
  - Latch addr, funct3, we, wdata.
  - Fault checks:
    - funct3 not in {000,001,010,100,101} for loads, or not in {000,001,010} for stores.
    - Halfword with addr[0]=1, or word with addr[1:0]!=0.
    - addr[31:DEPTH_LOG2+2] nonzero.
  - Fault -> RESP with err=1; no memory cycle.
  - Otherwise: load -> LOAD; SW -> STORE; SB/SH -> RMW.
- Memory drive outside LOAD/RMW/STORE: mem_A=0, mem_WE=0, mem_WD=0.
- LOAD:
  - Drive mem_A, mem_WE=0, and sample mem_RD.
  - Select the byte lane by addr[1:0] or the half by addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through. Register into resp_rdata.
  - Next state: RESP.
- RMW:
  - Drive mem_A and sample mem_RD into the merge register.
  - Replace the target byte (lane addr[1:0]) with wdata[7:0], or the half (addr[1]) with wdata[15:0]; other lanes are preserved.
  - Next state: STORE.
- STORE:
  - Drive mem_A, mem_WE=1, mem_WD = merged word (sub-word) or wdata (SW).
  - The write commits at the edge leaving STORE. Next state: RESP.
- RESP: resp_valid=1 for exactly one cycle, req_ready=0; then IDLE.
- Latency from the accept edge to the resp_valid cycle: fault 1 cycle; load 2; SW 2; SB/SH 3.
- Throughput: a new request can be accepted in the cycle after RESP.
- req_valid asserted while not ready is ignored; the core must hold the request until accepted.
- resp_rdata and resp_err keep their value until the next RESP and are cleared on accept.

Optional Feature:
- Macro LSU_SUBWORD_EN.
- Defined: full byte/half load and store support as above.
- Undefined:
  - Only funct3=010 (LW/SW) is legal; every other funct3 -> RESP with err=1 and no memory access.
  - The RMW state and lane-merge logic are not generated.

Test Plan:
- Memory word 7 = 0x8000_00F0; LB addr 0x1C -> resp after 2 cycles, rdata=0xFFFF_FFF0, err=0; LBU addr 0x1C -> 0x0000_00F0; LH addr 0x1E -> 0xFFFF_8000.
- Word 7 = 0x1122_3344; SB addr 0x1D wdata 0xAB -> mem_WE high exactly one cycle, 3 cycles to resp, word 7 = 0x1122_AB44.
- SW addr 0x20 wdata 0xDEAD_BEEF -> mem_A=8, word 8 = 0xDEAD_BEEF; a following LW addr 0x20 returns 0xDEAD_BEEF.
- LW addr 0x22; SH addr 0x13; LW addr 0x1000 (DEPTH_LOG2=10); funct3=011 -> each gives resp 1 cycle after accept with err=1, rdata=0, no mem_WE pulse.
- Assert rst=0 while in STORE of SB to word 3 (value 0x5555_5555) -> mem_WE falls asynchronously, word 3 unchanged, no resp_valid, req_ready=1 one cycle after release.
- Build without LSU_SUBWORD_EN: LB addr 0x1C -> err=1; LW addr 0x1C -> correct word, err=0.

Source files
------------

// File: rtl/lsu_mem_master.sv
// Load/store initiator: turns core byte-address requests into word-index memory cycles.
// Define LSU_SUBWORD_EN for byte/half loads and stores (read-modify-write); otherwise LW/SW only.
module lsu_mem_master #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_A,
  output logic        mem_WE,
  output logic [31:0] mem_WD,
  input  logic [31:0] mem_RD
);

  localparam int AW = DEPTH_LOG2 + 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_STORE = 3'd2,
    S_RESP  = 3'd3
`ifdef LSU_SUBWORD_EN
    , S_RMW = 3'd4
`endif
  } state_t;

  state_t      state_q;
  logic        ready_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic        resp_err_q;
  logic [31:0] mem_a_q;
  logic        mem_we_q;
  logic [31:0] mem_wd_q;

  logic        f3_ok_d;
  logic        align_ok_d;
  logic        range_ok_d;
  logic        fault_d;
  logic [31:0] idx_d;

`ifdef LSU_SUBWORD_EN
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;

  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  lane);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  load_extend = {{24{b[7]}}, b};
      3'b001:  load_extend = {{16{h[15]}}, h};
      3'b100:  load_extend = {24'd0, b};
      3'b101:  load_extend = {16'd0, h};
      default: load_extend = word;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  lane,
                                              input logic [15:0] wd);
    logic [31:0] r;
    r = word;
    if (f3 == 3'b000) begin
      r[{lane, 3'b000} +: 8] = wd[7:0];
    end else if (lane[1]) begin
      r[31:16] = wd;
    end else begin
      r[15:0] = wd;
    end
    store_merge = r;
  endfunction
`endif

  // Accept-time decode: legality, alignment and range of the incoming request.
  always_comb begin
    f3_ok_d    = 1'b0;
    align_ok_d = 1'b1;
`ifdef LSU_SUBWORD_EN
    case (req_funct3)
      3'b000: f3_ok_d = 1'b1;
      3'b001: begin
        f3_ok_d    = 1'b1;
        align_ok_d = ~req_addr[0];
      end
      3'b010: begin
        f3_ok_d    = 1'b1;
        align_ok_d = (req_addr[1:0] == 2'b00);
      end
      3'b100: f3_ok_d = ~req_we;
      3'b101: begin
        f3_ok_d    = ~req_we;
        align_ok_d = ~req_addr[0];
      end
      default: f3_ok_d = 1'b0;
    endcase
`else
    f3_ok_d    = (req_funct3 == 3'b010);
    align_ok_d = (req_addr[1:0] == 2'b00);
`endif
    range_ok_d = ((req_addr >> AW) == 32'd0);
    fault_d    = ~(f3_ok_d & align_ok_d & range_ok_d);
    idx_d      = 32'(req_addr[AW-1:2]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      ready_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'd0;
      resp_err_q   <= 1'b0;
      mem_a_q      <= 32'd0;
      mem_we_q     <= 1'b0;
      mem_wd_q     <= 32'd0;
`ifdef LSU_SUBWORD_EN
      funct3_q     <= 3'd0;
      lane_q       <= 2'd0;
      wdata_q      <= 16'd0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid && ready_q) begin
            ready_q      <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
`ifdef LSU_SUBWORD_EN
            funct3_q     <= req_funct3;
            lane_q       <= req_addr[1:0];
            wdata_q      <= req_wdata[15:0];
`endif
            if (fault_d) begin
              state_q      <= S_RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
            end else if (!req_we) begin
              state_q <= S_LOAD;
              mem_a_q <= idx_d;
`ifdef LSU_SUBWORD_EN
            end else if (req_funct3 != 3'b010) begin
              state_q <= S_RMW;
              mem_a_q <= idx_d;
`endif
            end else begin
              state_q  <= S_STORE;
              mem_a_q  <= idx_d;
              mem_we_q <= 1'b1;
              mem_wd_q <= req_wdata;
            end
          end else begin
            ready_q <= 1'b1;
          end
        end
        S_LOAD: begin
`ifdef LSU_SUBWORD_EN
          resp_rdata_q <= load_extend(mem_RD, funct3_q, lane_q);
`else
          resp_rdata_q <= mem_RD;
`endif
          mem_a_q      <= 32'd0;
          resp_valid_q <= 1'b1;
          state_q      <= S_RESP;
        end
`ifdef LSU_SUBWORD_EN
        // The merged word goes straight into the write-data register for STORE.
        S_RMW: begin
          mem_wd_q <= store_merge(mem_RD, funct3_q, lane_q, wdata_q);
          mem_we_q <= 1'b1;
          state_q  <= S_STORE;
        end
`endif
        S_STORE: begin
          mem_we_q     <= 1'b0;
          mem_wd_q     <= 32'd0;
          mem_a_q      <= 32'd0;
          resp_valid_q <= 1'b1;
          state_q      <= S_RESP;
        end
        S_RESP: begin
          resp_valid_q <= 1'b0;
          ready_q      <= 1'b1;
          state_q      <= S_IDLE;
        end
        default: begin
          ready_q  <= 1'b0;
          mem_we_q <= 1'b0;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_A      = mem_a_q;
  assign mem_WE     = mem_we_q;
  assign mem_WD     = mem_wd_q;

endmodule

// File: tb/tb_lsu_mem_master.sv
// Scoreboard bench for lsu_mem_master with a behavioural word memory.
module tb_lsu_mem_master;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_A;
  logic        mem_WE;
  logic [31:0] mem_WD;
  logic [31:0] mem_RD;

  logic [31:0] mem [0:1023];
  logic        pl_en = 1'b0;
  logic [9:0]  pl_idx = 10'd0;
  logic [31:0] pl_val = 32'd0;

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          wes;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] last_wa;

  always #5 clk = ~clk;

  lsu_mem_master #(.DEPTH_LOG2(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_A      (mem_A),
    .mem_WE     (mem_WE),
    .mem_WD     (mem_WD),
    .mem_RD     (mem_RD)
  );

  assign mem_RD = mem[mem_A[9:0]];

  always @(posedge clk) begin
    if (mem_WE) mem[mem_A[9:0]] <= mem_WD;
    else if (pl_en) mem[pl_idx] <= pl_val;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] val);
    @(negedge clk);
    pl_en  = 1'b1;
    pl_idx = 10'(idx);
    pl_val = val;
    @(negedge clk);
    pl_en  = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int guard;
    guard = 0;
    @(negedge clk);
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check_val({tag, "_ready"}, 32'(req_ready), 32'd1);
  endtask

  task automatic run_req(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rd, input logic exp_err,
                         input int exp_lat, input int exp_wes);
    exp_t e;
    int   lat;
    int   wes;
    bit   got;
    e.tag   = tag;
    e.rdata = exp_rd;
    e.err   = exp_err;
    e.lat   = exp_lat;
    e.wes   = exp_wes;
    sb_q.push_back(e);
    wait_ready(tag);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    lat = 0;
    wes = 0;
    got = 1'b0;
    last_wa = 32'hFFFF_FFFF;
    while (!got && lat < 20) begin
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      lat++;
      if (mem_WE) begin
        wes++;
        last_wa = mem_A;
      end
      if (resp_valid) got = 1'b1;
    end
    if (!got) begin
      check_val({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      check_val({e.tag, "_rdata"}, resp_rdata, e.rdata);
      check_val({e.tag, "_err"}, 32'(resp_err), 32'(e.err));
      check_val({e.tag, "_lat"}, 32'(lat), 32'(e.lat));
      check_val({e.tag, "_we_cycles"}, 32'(wes), 32'(e.wes));
      @(posedge clk);
      #1;
      check_val({e.tag, "_pulse"}, 32'(resp_valid), 32'd0);
    end
  endtask

  initial begin
    #12;
    check_val("rst_ready", 32'(req_ready), 32'd0);
    check_val("rst_resp_valid", 32'(resp_valid), 32'd0);
    check_val("rst_rdata", resp_rdata, 32'd0);
    check_val("rst_err", 32'(resp_err), 32'd0);
    check_val("rst_mem_a", mem_A, 32'd0);
    check_val("rst_mem_we", 32'(mem_WE), 32'd0);
    check_val("rst_mem_wd", mem_WD, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_val("release_ready", 32'(req_ready), 32'd1);

    preload(7, 32'h8000_00F0);
`ifdef LSU_SUBWORD_EN
    run_req("lb_neg",  1'b0, 3'b000, 32'h1C, 32'd0, 32'hFFFF_FFF0, 1'b0, 2, 0);
    run_req("lbu",     1'b0, 3'b100, 32'h1C, 32'd0, 32'h0000_00F0, 1'b0, 2, 0);
    run_req("lh_neg",  1'b0, 3'b001, 32'h1E, 32'd0, 32'hFFFF_8000, 1'b0, 2, 0);
    run_req("lhu",     1'b0, 3'b101, 32'h1E, 32'd0, 32'h0000_8000, 1'b0, 2, 0);
`else
    run_req("lb_off",  1'b0, 3'b000, 32'h1C, 32'd0, 32'd0, 1'b1, 1, 0);
    run_req("lbu_off", 1'b0, 3'b100, 32'h1C, 32'd0, 32'd0, 1'b1, 1, 0);
    run_req("lh_off",  1'b0, 3'b001, 32'h1E, 32'd0, 32'd0, 1'b1, 1, 0);
`endif
    run_req("lw7", 1'b0, 3'b010, 32'h1C, 32'd0, 32'h8000_00F0, 1'b0, 2, 0);

    preload(7, 32'h1122_3344);
`ifdef LSU_SUBWORD_EN
    run_req("sb", 1'b1, 3'b000, 32'h1D, 32'h0000_00AB, 32'd0, 1'b0, 3, 1);
    check_val("sb_mem7", mem[7], 32'h1122_AB44);
    check_val("sb_addr", last_wa, 32'd7);
`else
    run_req("sb_off", 1'b1, 3'b000, 32'h1D, 32'h0000_00AB, 32'd0, 1'b1, 1, 0);
    check_val("sb_off_mem7", mem[7], 32'h1122_3344);
`endif

    run_req("sw", 1'b1, 3'b010, 32'h20, 32'hDEAD_BEEF, 32'd0, 1'b0, 2, 1);
    check_val("sw_addr", last_wa, 32'd8);
    check_val("sw_mem8", mem[8], 32'hDEAD_BEEF);
    run_req("lw8", 1'b0, 3'b010, 32'h20, 32'd0, 32'hDEAD_BEEF, 1'b0, 2, 0);

`ifdef LSU_SUBWORD_EN
    run_req("sh_hi", 1'b1, 3'b001, 32'h22, 32'h1234_CAFE, 32'd0, 1'b0, 3, 1);
    check_val("sh_mem8", mem[8], 32'hCAFE_BEEF);
`else
    run_req("sh_off", 1'b1, 3'b001, 32'h22, 32'h1234_CAFE, 32'd0, 1'b1, 1, 0);
    check_val("sh_off_mem8", mem[8], 32'hDEAD_BEEF);
`endif

    run_req("lw_misal",  1'b0, 3'b010, 32'h22,   32'd0, 32'd0, 1'b1, 1, 0);
    run_req("sh_misal",  1'b1, 3'b001, 32'h13,   32'hFFFF, 32'd0, 1'b1, 1, 0);
    run_req("lw_range",  1'b0, 3'b010, 32'h1000, 32'd0, 32'd0, 1'b1, 1, 0);
    run_req("f3_011",    1'b0, 3'b011, 32'h1C,   32'd0, 32'd0, 1'b1, 1, 0);
    run_req("st_f3_100", 1'b1, 3'b100, 32'h1C,   32'h55, 32'd0, 1'b1, 1, 0);
    run_req("sw_range",  1'b1, 3'b010, 32'h8000_0000, 32'h1, 32'd0, 1'b1, 1, 0);

    // Reset while the write to word 3 is being presented.
    preload(3, 32'h5555_5555);
    wait_ready("midrst");
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_addr   = 32'h0C;
`ifdef LSU_SUBWORD_EN
    req_funct3 = 3'b000;
    req_wdata  = 32'h0000_00AA;
`else
    req_funct3 = 3'b010;
    req_wdata  = 32'h1234_5678;
`endif
    @(posedge clk);
    #1;
    req_valid = 1'b0;
`ifdef LSU_SUBWORD_EN
    @(posedge clk);
    #1;
`endif
    check_val("midrst_we_before", 32'(mem_WE), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check_val("midrst_we_async", 32'(mem_WE), 32'd0);
    check_val("midrst_ready", 32'(req_ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check_val("midrst_no_resp", 32'(resp_valid), 32'd0);
    check_val("midrst_mem3", mem[3], 32'h5555_5555);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_val("midrst_ready_after", 32'(req_ready), 32'd1);
    check_val("midrst_resp_after", 32'(resp_valid), 32'd0);
    run_req("lw3_after", 1'b0, 3'b010, 32'h0C, 32'd0, 32'h5555_5555, 1'b0, 2, 0);

    check_val("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
